// File: rtl/comp_seq_ctrl_pkg.sv
// Shared definitions for the digit-serial comparator sequencer:
// state encodings, slice width, result struct and index-width helper.
package comp_seq_ctrl_pkg;

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_RUN  = 2'b01;
    localparam logic [1:0] ST_DONE = 2'b10;

    localparam int DIG_W = 2;

    typedef struct packed {
        logic l;
        logic e;
        logic g;
    } lge_t;

    // A single-digit operand still needs a 1-bit index register.
    function automatic int idx_w(input int ndig);
        return (ndig > 1) ? $clog2(ndig) : 1;
    endfunction

endpackage

// File: rtl/comp_2bit.sv
// 2-bit magnitude comparator slice: exactly one of l/e/g is high.
module comp_2bit (
    input  logic [1:0] a,
    input  logic [1:0] b,
    output logic       l,
    output logic       e,
    output logic       g
);

    assign l = (a < b);
    assign e = (a == b);
    assign g = (a > b);

endmodule

// File: rtl/comp_seq_ctrl.sv
// Compares two WIDTH-bit operands MSB-first through one shared 2-bit slice,
// one digit per clock, stopping at the first unequal digit.
module comp_seq_ctrl
    import comp_seq_ctrl_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             l,
    output logic             e,
    output logic             g
);

    localparam int NDIG = WIDTH / 2;
    localparam int IW   = idx_w(NDIG);

    logic [1:0]       state;
    logic [IW-1:0]    idx;
    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;
    lge_t             res;
    logic             done_q;
    logic [DIG_W-1:0] dig_a;
    logic [DIG_W-1:0] dig_b;
    logic             sl;
    logic             se;
    logic             sg;

    assign dig_a = opa[idx*DIG_W +: DIG_W];
    assign dig_b = opb[idx*DIG_W +: DIG_W];

    comp_2bit u_slice (
        .a (dig_a),
        .b (dig_b),
        .l (sl),
        .e (se),
        .g (sg)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= ST_IDLE;
            idx    <= '0;
            opa    <= '0;
            opb    <= '0;
            res    <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        opa   <= a;
                        opb   <= b;
                        res   <= '0;
                        idx   <= IW'(NDIG - 1);
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    // First unequal digit decides; all-equal falls through to e.
                    if (sl || sg) begin
                        res    <= '{l: sl, e: 1'b0, g: sg};
                        done_q <= 1'b1;
                        state  <= ST_DONE;
                    end else if (se && idx == '0) begin
                        res.e  <= 1'b1;
                        done_q <= 1'b1;
                        state  <= ST_DONE;
                    end else if (se) begin
                        idx <= idx - IW'(1);
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign busy = (state != ST_IDLE);
    assign done = done_q;
    assign l    = res.l;
    assign e    = res.e;
    assign g    = res.g;

endmodule
